// File: rtl/diamond_collect_ctrl.sv
// Diamond collection controller: each frame_tick scans six diamonds once and credits the matching-colour player.
// Optional macro DIAMOND_RESPAWN_EN lets level_restart restore all diamonds and scores.
module diamond_collect_ctrl #(
    parameter logic [5:0] RED_MASK = 6'b000111
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [5:0] fire_hit,
    input  logic [5:0] water_hit,
    input  logic       level_restart,
    output logic [5:0] visible,
    output logic [2:0] fire_score,
    output logic [2:0] water_score,
    output logic       collect_pulse,
    output logic [2:0] collect_idx,
    output logic       busy,
    output logic       all_collected
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_idx;
    logic [5:0] r_fire_snap;
    logic [5:0] r_water_snap;
    logic [5:0] r_visible;
    logic [2:0] r_fire_score;
    logic [2:0] r_water_score;
    logic       r_pulse;
    logic [2:0] r_cidx;
    logic       r_busy;
    logic       r_all;
    logic       w_restart;
    logic       w_red;
    logic       w_qual;

    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v == 3'd7) ? v : (v + 3'd1);
    endfunction

`ifdef DIAMOND_RESPAWN_EN
    assign w_restart = level_restart;
`else
    logic w_unused_restart;
    assign w_unused_restart = level_restart;
    assign w_restart        = 1'b0;
`endif

    // Next-state logic and qualification of the diamond under the scan index
    always_comb begin
        w_next_state = r_state;
        w_red        = RED_MASK[r_idx];
        w_qual       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frame_tick) begin
                    w_next_state = ST_SCAN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SCAN: begin
                w_qual = r_visible[r_idx] &
                         (w_red ? r_fire_snap[r_idx] : r_water_snap[r_idx]);
                if (r_idx == 3'd5) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_SCAN;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register; reset and restart both force IDLE
    always_ff @(posedge Clk) begin
        if (Reset || w_restart) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath: snapshots, scan index, visibility, scores and strobes
    always_ff @(posedge Clk) begin
        if (Reset || w_restart) begin
            r_idx         <= 3'd0;
            r_fire_snap   <= 6'd0;
            r_water_snap  <= 6'd0;
            r_visible     <= 6'b111111;
            r_fire_score  <= 3'd0;
            r_water_score <= 3'd0;
            r_pulse       <= 1'b0;
            r_cidx        <= 3'd0;
            r_busy        <= 1'b0;
            r_all         <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            r_busy  <= (w_next_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (frame_tick) begin
                        r_fire_snap  <= fire_hit;
                        r_water_snap <= water_hit;
                        r_idx        <= 3'd0;
                    end
                end
                ST_SCAN: begin
                    if (w_qual) begin
                        r_visible[r_idx] <= 1'b0;
                        r_pulse          <= 1'b1;
                        r_cidx           <= r_idx;
                        if (w_red) begin
                            r_fire_score <= sat_inc(r_fire_score);
                        end else begin
                            r_water_score <= sat_inc(r_water_score);
                        end
                    end
                    r_idx <= (r_idx == 3'd5) ? 3'd0 : (r_idx + 3'd1);
                end
                ST_DONE: begin
                    // visible already reflects the idx 5 decision made at the previous edge
                    if (r_visible == 6'd0) begin
                        r_all <= 1'b1;
                    end
                    r_idx <= 3'd0;
                end
                default: begin
                    r_idx <= 3'd0;
                end
            endcase
        end
    end

    assign visible       = r_visible;
    assign fire_score    = r_fire_score;
    assign water_score   = r_water_score;
    assign collect_pulse = r_pulse;
    assign collect_idx   = r_cidx;
    assign busy          = r_busy;
    assign all_collected = r_all;

endmodule

// File: tb/tb_diamond_collect_ctrl.sv
// Self-checking bench for diamond_collect_ctrl: directed vector table, hand-written corner sequences,
// and randomized scans against a transaction-level model.
module tb_diamond_collect_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic [5:0] fire_hit = 6'd0;
    logic [5:0] water_hit = 6'd0;
    logic       level_restart = 1'b0;
    logic [5:0] visible;
    logic [2:0] fire_score;
    logic [2:0] water_score;
    logic       collect_pulse;
    logic [2:0] collect_idx;
    logic       busy;
    logic       all_collected;

    diamond_collect_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .fire_hit(fire_hit), .water_hit(water_hit), .level_restart(level_restart),
        .visible(visible), .fire_score(fire_score), .water_score(water_score),
        .collect_pulse(collect_pulse), .collect_idx(collect_idx),
        .busy(busy), .all_collected(all_collected)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [5:0] red_mask = 6'b000111;
    logic [5:0] m_vis;
    int         m_fs;
    int         m_ws;
    bit         m_all;

    typedef struct {
        bit         rst;
        logic [5:0] f;
        logic [5:0] w;
        bit         tick_mid;
        logic [5:0] ev;
        int         efs;
        int         ews;
        bit         eall;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_vis = 6'b111111;
        m_fs  = 0;
        m_ws  = 0;
        m_all = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_vis"}, int'(visible), 63);
        chk({tag, "_fs"}, int'(fire_score), 0);
        chk({tag, "_ws"}, int'(water_score), 0);
        chk({tag, "_pulse"}, int'(collect_pulse), 0);
        chk({tag, "_idx"}, int'(collect_idx), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_all"}, int'(all_collected), 0);
    endtask

    // frame_tick is held high during reset to show reset wins
    task automatic do_reset();
        Reset = 1'b1;
        frame_tick = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        frame_tick = 1'b0;
        model_reset();
        check_reset_vals("rst");
        @(posedge Clk); #1;
        chk("rst_no_scan", int'(busy), 0);
    endtask

    task automatic drive_noise(input bit tick_val);
        fire_hit   = 6'($urandom);
        water_hit  = 6'($urandom);
        frame_tick = tick_val;
    endtask

    // Called #1 after an edge; the scan starts at the next edge (E0)
    task automatic do_scan(input logic [5:0] f, input logic [5:0] w, input bit tick_mid);
        bit q;
        frame_tick = 1'b1;
        fire_hit   = f;
        water_hit  = w;
        @(posedge Clk); #1;
        chk("busy_start", int'(busy), 1);
        drive_noise(tick_mid ? 1'b0 : 1'($urandom_range(0, 1)));
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk); #1;
            q = m_vis[i] && (red_mask[i] ? f[i] : w[i]);
            if (q) begin
                m_vis[i] = 1'b0;
                if (red_mask[i]) m_fs = (m_fs < 7) ? m_fs + 1 : 7;
                else             m_ws = (m_ws < 7) ? m_ws + 1 : 7;
            end
            chk("pulse", int'(collect_pulse), int'(q));
            if (q) chk("cidx", int'(collect_idx), i);
            chk("vis", int'(visible), int'(m_vis));
            chk("fs", int'(fire_score), m_fs);
            chk("ws", int'(water_score), m_ws);
            chk("busy_scan", int'(busy), 1);
            chk("all_scan", int'(all_collected), int'(m_all));
            drive_noise(tick_mid ? (i == 1) : 1'($urandom_range(0, 1)));
        end
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        fire_hit   = 6'd0;
        water_hit  = 6'd0;
        if (m_vis == 6'd0) m_all = 1;
        chk("busy_end", int'(busy), 0);
        chk("pulse_end", int'(collect_pulse), 0);
        chk("all_end", int'(all_collected), int'(m_all));
        @(posedge Clk); #1;
        chk("idle_after", int'(busy), 0);
    endtask

    initial begin
        //          rst  fire        water       mid   vis         fs ws all
        tbl[0] = '{1'b1, 6'b000001, 6'b000000, 1'b0, 6'b111110, 1, 0, 1'b0};
        tbl[1] = '{1'b1, 6'b000000, 6'b000001, 1'b0, 6'b111111, 0, 0, 1'b0};
        tbl[2] = '{1'b0, 6'b000001, 6'b000000, 1'b0, 6'b111110, 1, 0, 1'b0};
        tbl[3] = '{1'b1, 6'b000111, 6'b111000, 1'b0, 6'b000000, 3, 3, 1'b1};
        tbl[4] = '{1'b1, 6'b000001, 6'b000000, 1'b1, 6'b111110, 1, 0, 1'b0};
        tbl[5] = '{1'b0, 6'b111111, 6'b111111, 1'b0, 6'b000000, 3, 3, 1'b1};
        tbl[6] = '{1'b0, 6'b111111, 6'b111111, 1'b0, 6'b000000, 3, 3, 1'b1};

        model_reset();
        @(posedge Clk); #1;
        do_reset();

        for (int k = 0; k < 7; k++) begin
            if (tbl[k].rst) do_reset();
            do_scan(tbl[k].f, tbl[k].w, tbl[k].tick_mid);
            chk("tbl_vis", int'(visible), int'(tbl[k].ev));
            chk("tbl_fs", int'(fire_score), tbl[k].efs);
            chk("tbl_ws", int'(water_score), tbl[k].ews);
            chk("tbl_all", int'(all_collected), int'(tbl[k].eall));
        end

        // level_restart after everything was collected
        level_restart = 1'b1;
        @(posedge Clk); #1;
        level_restart = 1'b0;
`ifdef DIAMOND_RESPAWN_EN
        model_reset();
        check_reset_vals("restart");
`else
        chk("norestart_vis", int'(visible), 0);
        chk("norestart_fs", int'(fire_score), 3);
        chk("norestart_ws", int'(water_score), 3);
        chk("norestart_all", int'(all_collected), 1);
`endif

        // reset at E0+2 aborts the scan after the idx 0 collection
        do_reset();
        frame_tick = 1'b1;
        fire_hit   = 6'b000111;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        @(posedge Clk); #1;
        chk("abort_pulse", int'(collect_pulse), 1);
        chk("abort_cidx", int'(collect_idx), 0);
        chk("abort_vis", int'(visible), 62);
        chk("abort_fs", int'(fire_score), 1);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        fire_hit = 6'd0;
        model_reset();
        check_reset_vals("abort");
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk); #1;
            chk("abort_quiet_pulse", int'(collect_pulse), 0);
            chk("abort_quiet_vis", int'(visible), 63);
        end

        // randomized scans against the model
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 5) == 0) do_reset();
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                @(posedge Clk); #1;
                chk("gap_pulse", int'(collect_pulse), 0);
                chk("gap_busy", int'(busy), 0);
            end
            do_scan(6'($urandom & $urandom), 6'($urandom & $urandom), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/diamond_collect_ctrl.md
DIAMOND_COLLECT_CTRL -- requirements
Module: diamond_collect_ctrl

Interface
REQ-001 The block SHALL have parameter RED_MASK, default 6'b000111, meaning bit i=1 marks diamond i as red (fire-collectable) and bit i=0 marks it as blue (water-collectable).
REQ-002 The block SHALL have port Clk  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port frame_tick  input  1  one-cycle pulse that starts one collection scan.
REQ-005 The block SHALL have port fire_hit  input  6  bit i = fire player overlaps diamond i.
REQ-006 The block SHALL have port water_hit  input  6  bit i = water player overlaps diamond i.
REQ-007 The block SHALL have port level_restart  input  1  restores all diamonds; used only when DIAMOND_RESPAWN_EN is defined.
REQ-008 The block SHALL have port visible  output  6  bit i = diamond i still on screen.
REQ-009 The block SHALL have port fire_score  output  3  red diamonds collected.
REQ-010 The block SHALL have port water_score  output  3  blue diamonds collected.
REQ-011 The block SHALL have port collect_pulse  output  1  one-cycle strobe per collection.
REQ-012 The block SHALL have port collect_idx  output  3  index of the diamond collected in the strobed cycle.
REQ-013 The block SHALL have port busy  output  1  high while a scan is in progress.
REQ-014 The block SHALL have port all_collected  output  1  sticky; high once visible==0.

Function
REQ-015 The FSM SHALL have states IDLE, SCAN and DONE.
REQ-016 In IDLE, when frame_tick=1 at an edge E0: fire_hit/water_hit snapshot latched, idx=0, go to SCAN.
REQ-017 In SCAN, idx=i is evaluated during the cycle after edge E0+i; diamond i qualifies if visible[i]=1 and (RED_MASK[i]&fire_snap[i] or !RED_MASK[i]&water_snap[i]).
REQ-018 A qualifying diamond SHALL, at edge E0+i+1: clear visible[i]; increment fire_score (red) or water_score (blue), saturating at 7; set collect_pulse=1 and collect_idx=i for exactly one cycle.
REQ-019 Non-qualifying idx (wrong colour, no hit, already collected) SHALL cause no output change and collect_pulse=0.
REQ-020 In SCAN, idx increments every cycle; after idx=5 the FSM SHALL go to DONE at edge E0+6.
REQ-021 In DONE, all_collected SHALL be set if visible==0, then the FSM returns to IDLE at edge E0+7.
REQ-022 busy SHALL be 1 in SCAN and DONE and 0 in IDLE (cycles E0..E0+6 inclusive).
REQ-023 frame_tick while busy=1 SHALL be ignored; hit inputs that change mid-scan SHALL not affect the scan.
REQ-024 Both players overlapping the same diamond SHALL credit only the matching-colour player.
REQ-025 Hits on an already-invisible diamond SHALL never re-credit a score.

Reset
REQ-026 Reset=1 at an edge SHALL force: IDLE, idx=0, visible=6'b111111, fire_score=0, water_score=0, collect_pulse=0, collect_idx=0, busy=0, all_collected=0, snapshots=0.
REQ-027 Reset asserted mid-scan SHALL abort the scan with no further collections, and SHALL take priority over frame_tick and level_restart.

Configuration
REQ-028 With macro DIAMOND_RESPAWN_EN defined, level_restart=1 at an edge (Reset=0) SHALL apply the reset values of REQ-026 in any state and take priority over frame_tick.
REQ-029 Without DIAMOND_RESPAWN_EN, level_restart SHALL be ignored and only Reset restores diamonds.

Verification
REQ-030 Reset, then frame_tick with fire_hit=6'b000001 -> collect_pulse at edge E0+1 with collect_idx=0, visible=6'b111110, fire_score=1, busy low after E0+7.
REQ-031 water_hit=6'b000001 (red diamond 0), then a second scan with fire_hit=6'b000001 -> no collection, then a single pulse on the second scan only; fire_score=1, water_score=0.
REQ-032 fire_hit=6'b000111 and water_hit=6'b111000 in one tick -> six pulses idx 0..5 on consecutive cycles, scores 3/3, all_collected=1 after DONE.
REQ-033 Second frame_tick at E0+3 while busy -> ignored; only one scan, no double count.
REQ-034 Reset at E0+2 during a scan with fire_hit=6'b000111 -> only idx 0 pulse seen before reset; all outputs at reset values afterwards.
REQ-035 With DIAMOND_RESPAWN_EN defined, after all_collected=1, pulse level_restart -> visible=6'b111111, scores 0, all_collected=0; without the macro -> no change.
